// File: rtl/counter_scheduler.sv
// Round-robin time-sharing of one external flex_counter among NUM_REQ requesters.
// Latency: grant 1 cycle after request, done at dur+3, IDLE again at dur+4.
// Backpressure: losers hold req in IDLE; dropping req[owner] mid-run aborts the interval.
module counter_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*NUM_CNT_BITS-1:0] dur,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic                            cnt_clear,
    output logic                            cnt_enable,
    output logic [NUM_CNT_BITS-1:0]         cnt_rollover_val,
    input  logic                            cnt_rollover_flag
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        pick;
    logic [IDX_W-1:0]        owner_inc;
    logic                    any_req;
    logic                    owner_req;
    logic                    ptr_adv;
    logic [NUM_REQ-1:0]      owner_oh;
    logic [2*NUM_REQ-1:0]    req_dbl;
    logic [NUM_REQ-1:0]      req_rot;
    logic [NUM_CNT_BITS-1:0] pick_dur;

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        pick    = '0;
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req_rot[k]) begin
                any_req = 1'b1;
                idx     = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                pick = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        pick_dur = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_dur = dur[i*NUM_CNT_BITS +: NUM_CNT_BITS];
            end
            owner_oh[i] = (owner == IDX_W'(i));
        end
        owner_req = |(req & owner_oh);
        owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            owner            <= '0;
            ptr              <= '0;
            cnt_rollover_val <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req) begin
                owner            <= pick;
                cnt_rollover_val <= pick_dur;
            end
            if (ptr_adv) begin
                ptr <= owner_inc;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        done       = '0;
        ptr_adv    = 1'b0;
        busy       = (state != S_IDLE);
        gnt        = (state != S_IDLE) ? owner_oh : '0;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_clear = 1'b1;
                // A rollover value of zero never flags, so skip counting.
                state_nxt = (cnt_rollover_val == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (!owner_req) begin
                    cnt_clear = 1'b1;
                    ptr_adv   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_enable = ~cnt_rollover_flag;
                    if (cnt_rollover_flag) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done      = owner_oh;
                cnt_clear = 1'b1;
                ptr_adv   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
